// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard port.
// Optional KBD_IRQ_EN adds a registered irq output on kbd_port.
package kbd_pkg;

  localparam logic [15:0] KBD_DATA_PORT = 16'h0060;
  localparam logic [15:0] KBD_STAT_PORT = 16'h0064;

  localparam int ST_OBF  = 0;
  localparam int ST_OVR  = 1;
  localparam int ST_PERR = 2;
  localparam int ST_FERR = 3;

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       ferr;
    logic       perr;
    logic       ovr;
    logic       obf;
  } kbd_stat_t;

  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/kbd_port_if.sv
// CPU port-I/O bus seen by the keyboard port.
// The CPU drives the master side; kbd_port is the slave.
interface kbd_port_if;
  logic [15:0] address;
  logic [7:0]  out;
  logic        pr;
  logic        pw;
  logic [7:0]  port_in;
  logic        hit;

  modport master (
    output address, out, pr, pw,
    input  port_in, hit
  );

  modport slave (
    input  address, out, pr, pw,
    output port_in, hit
  );
endinterface

// File: rtl/kbd_port_ps2_rx.sv
// PS/2 receiver: synchroniser, clock glitch filter, frame FSM, timeout.
// Emits one-cycle valid/perr/ferr pulses; rx_byte holds the last frame.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       valid,
  output logic [7:0] rx_byte,
  output logic       perr,
  output logic       ferr
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  logic [1:0]    clk_s;
  logic [1:0]    dat_s;
  logic          filt;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] idle_cnt;
  logic          dat;

  assign dat     = dat_s[1];
  assign rx_byte = shreg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_dat};
    end
  end

  // Level flips only after FILTER consecutive disagreeing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt    <= 1'b1;
      flt_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s[1] == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt    <= clk_s[1];
        flt_cnt <= '0;
        fall    <= filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      idle_cnt <= '0;
      valid    <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      valid <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      if (state == RX_IDLE || fall)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      if (state != RX_IDLE && !fall && idle_cnt == TO_LAST) begin
        state <= RX_IDLE;
        ferr  <= 1'b1;
      end else if (fall) begin
        unique case (state)
          RX_IDLE: begin
            if (!dat) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state <= RX_PARITY;
          end
          RX_PARITY: begin
            par   <= dat;
            state <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            valid <= dat & odd_ok(shreg, par);
            perr  <= ~odd_ok(shreg, par);
            ferr  <= ~dat;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/kbd_port.sv
// PS/2 keyboard controller: receive FIFO, status flags, CPU port decode.
// Define KBD_IRQ_EN to add the registered irq output.
module kbd_port
  import kbd_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DATA_PORT = KBD_DATA_PORT,
  parameter logic [15:0] STAT_PORT = KBD_STAT_PORT,
  parameter int          FILTER    = 8,
  parameter int          TIMEOUT   = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  kbd_port_if.slave  bus,
  input  logic       ps2_clk,
  input  logic       ps2_dat
`ifdef KBD_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          rx_perr;
  logic          rx_ferr;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          empty;
  logic          full;

  logic          pr_q;
  logic          sel_data;
  logic          sel_stat;
  logic          pop;
  logic          push;
  logic          stat_wr;
  logic          ovr;
  logic          perr;
  logic          ferr;
  kbd_stat_t     stat;
  logic          unused_ok;

  ps2_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clock   (clock),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .valid   (rx_valid),
    .rx_byte (rx_byte),
    .perr    (rx_perr),
    .ferr    (rx_ferr)
  );

  assign sel_data = bus.address == DATA_PORT;
  assign sel_stat = bus.address == STAT_PORT;
  assign count    = wr_ptr - rd_ptr;
  assign empty    = wr_ptr == rd_ptr;
  assign full     = count == PW'(DEPTH);

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop     = bus.pr & ~pr_q & sel_data & ~empty;
  assign push    = rx_valid & (~full | pop);
  assign stat_wr = bus.pw & sel_stat;

  assign unused_ok = ^bus.out;

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pr_q   <= 1'b0;
    end else begin
      pr_q <= bus.pr;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovr  <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= (rx_valid & full & ~pop) | (ovr & ~stat_wr);
      perr <= rx_perr | (perr & ~stat_wr);
      ferr <= rx_ferr | (ferr & ~stat_wr);
    end
  end

`ifdef KBD_IRQ_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      irq <= 1'b0;
    else
      irq <= ~empty;
  end
`endif

  always_comb begin
    stat      = '0;
    stat.ferr = ferr;
    stat.perr = perr;
    stat.ovr  = ovr;
    stat.obf  = ~empty;
  end

  always_comb begin
    bus.hit     = bus.pr & (sel_data | sel_stat);
    bus.port_in = 8'hFF;
    case (1'b1)
      sel_data: bus.port_in = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
      sel_stat: bus.port_in = stat;
      default:  bus.port_in = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_kbd_port.sv
// Directed bench for kbd_port: frames, errors, overflow, timeout, reset.
// Builds with or without KBD_IRQ_EN.
module tb_kbd_port;
  import kbd_pkg::*;

  localparam int HP = 12;
  localparam int TO = 400;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
`ifdef KBD_IRQ_EN
  logic irq;
`endif

  kbd_port_if bus ();

  kbd_port #(
    .DEPTH   (16),
    .TIMEOUT (TO)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat)
`ifdef KBD_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #20 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ps2_bit(logic b);
    ps2_dat = b;
    tick(HP);
    ps2_clk = 1'b0;
    tick(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic frame(logic [7:0] d, logic flip);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++)
      ps2_bit(d[i]);
    ps2_bit((~^d) ^ flip);
    ps2_bit(1'b1);
    tick(HP);
  endtask

  task automatic rd(input logic [15:0] a,
                    output logic [7:0] d,
                    output logic h);
    bus.address = a;
    bus.pr      = 1'b1;
    @(negedge clock);
    d = bus.port_in;
    h = bus.hit;
    tick(1);
    bus.pr = 1'b0;
    tick(1);
  endtask

  task automatic rd_chk(string tag, logic [15:0] a, logic [7:0] exp);
    logic [7:0] d;
    logic       h;
    rd(a, d, h);
    chk(tag, d, exp);
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] v);
    bus.address = a;
    bus.out     = v;
    bus.pw      = 1'b1;
    tick(1);
    bus.pw = 1'b0;
    tick(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       h;

    bus.address = 16'h0060;
    bus.out     = 8'h00;
    bus.pr      = 1'b0;
    bus.pw      = 1'b0;
    tick(3);
    chk("rst_data_port", bus.port_in, 8'h00);
    chk("rst_hit_idle", {7'b0, bus.hit}, 8'h00);
`ifdef KBD_IRQ_EN
    chk("rst_irq", {7'b0, irq}, 8'h00);
`endif
    reset_n = 1'b1;
    tick(2);

    rd(16'h0064, d, h);
    chk("stat_after_reset", d, 8'h00);
    chk("hit_stat", {7'b0, h}, 8'h01);
    rd(16'h0070, d, h);
    chk("other_port_data", d, 8'hFF);
    chk("other_port_hit", {7'b0, h}, 8'h00);

    frame(8'h1C, 1'b0);
`ifdef KBD_IRQ_EN
    chk("irq_set", {7'b0, irq}, 8'h01);
`endif
    rd_chk("good_stat", 16'h0064, 8'h01);
    rd_chk("good_data", 16'h0060, 8'h1C);
    rd_chk("good_stat_after", 16'h0064, 8'h00);
`ifdef KBD_IRQ_EN
    chk("irq_clear", {7'b0, irq}, 8'h00);
`endif

    frame(8'h1C, 1'b1);
    rd_chk("perr_stat", 16'h0064, 8'h04);
    rd_chk("perr_empty", 16'h0060, 8'h00);
    wr(16'h0060, 8'h00);
    rd_chk("perr_data_wr_ignored", 16'h0064, 8'h04);
    wr(16'h0064, 8'h00);
    rd_chk("perr_cleared", 16'h0064, 8'h00);

    for (int i = 1; i <= 17; i++)
      frame(8'(i), 1'b0);
    rd_chk("ovr_stat", 16'h0064, 8'h03);
    for (int i = 1; i <= 16; i++)
      rd_chk($sformatf("fifo_%0d", i), 16'h0060, 8'(i));
    rd_chk("fifo_drained", 16'h0060, 8'h00);
    rd_chk("ovr_sticky", 16'h0064, 8'h02);
    wr(16'h0064, 8'h00);
    rd_chk("ovr_cleared", 16'h0064, 8'h00);

    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    tick(TO + 50);
    rd_chk("timeout_ferr", 16'h0064, 8'h08);
    frame(8'h5A, 1'b0);
    rd_chk("timeout_stat", 16'h0064, 8'h09);
    rd_chk("timeout_data", 16'h0060, 8'h5A);
    wr(16'h0064, 8'h00);
    rd_chk("ferr_cleared", 16'h0064, 8'h00);

    frame(8'h33, 1'b0);
    frame(8'h44, 1'b0);
    bus.address = 16'h0060;
    bus.pr      = 1'b1;
    @(negedge clock);
    chk("hold_first", bus.port_in, 8'h33);
    tick(4);
    @(negedge clock);
    chk("hold_next_head", bus.port_in, 8'h44);
    tick(1);
    bus.pr = 1'b0;
    tick(1);
    rd_chk("hold_one_left", 16'h0064, 8'h01);
    rd_chk("hold_second", 16'h0060, 8'h44);
    rd_chk("hold_empty", 16'h0064, 8'h00);

    frame(8'h77, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    reset_n     = 1'b0;
    bus.address = 16'h0060;
    bus.pr      = 1'b1;
    #1;
    chk("midrst_data", bus.port_in, 8'h00);
    chk("midrst_hit", {7'b0, bus.hit}, 8'h01);
    bus.address = 16'h0064;
    #1;
    chk("midrst_stat", bus.port_in, 8'h00);
`ifdef KBD_IRQ_EN
    chk("midrst_irq", {7'b0, irq}, 8'h00);
`endif
    tick(2);
    bus.pr = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    rd_chk("postrst_stat", 16'h0064, 8'h00);
    frame(8'h2A, 1'b0);
    rd_chk("postrst_ready", 16'h0064, 8'h01);
    rd_chk("postrst_data", 16'h0060, 8'h2A);
    rd_chk("postrst_empty", 16'h0064, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kbd_port.md
# kbd_port

PS/2 keyboard controller that answers CPU port-I/O cycles. It deserialises scan codes from the PS/2 connector into a receive FIFO and returns them on reads of port 60h. It also exposes a status byte on port 64h. It sits beside the CPU core on the 25 MHz domain, and the top level muxes its `port_in` into the CPU `in` bus when `hit` is high.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `DATA_PORT`, 16'h0060: scan-code read port.
- `STAT_PORT`, 16'h0064: status read port; writing it clears the sticky flags.
- `FILTER`, 8: consecutive equal samples required before a PS/2 clock level is accepted.
- `TIMEOUT`, 50000: idle cycles allowed mid-frame before abort (2 ms at 25 MHz).

Ports:
- `clock` in 1: system clock, 25 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 16: port number, taken from CPU `address[15:0]`.
- `out` in 8: CPU write data.
- `pr` in 1: CPU port-read strobe.
- `pw` in 1: CPU port-write strobe.
- `port_in` out 8: read data, combinational.
- `hit` out 1: combinational; high when `pr` is high and `address` is `DATA_PORT` or `STAT_PORT`.
- `ps2_clk` in 1: PS/2 clock, asynchronous.
- `ps2_dat` in 1: PS/2 data, asynchronous.
- `irq` out 1: present only with `KBD_IRQ_EN`.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_dat` each pass through a 2-flop synchroniser.
  - The filtered clock level changes only after `FILTER` equal consecutive samples.
  - A falling edge of the filtered clock is one `fall` pulse.
- Receiver FSM, advanced on `fall`:
  - IDLE: `dat`=0 → DATA with bit counter 0. `dat`=1 → stay in IDLE.
  - DATA: shift `dat` in LSB-first; after the 8th bit → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: always → IDLE. Then:
    - If `dat`=1 and odd parity holds over data+parity, push the byte.
    - If parity fails, set `perr` and drop the byte.
    - If `dat`=0, set `ferr` and drop the byte.
- Timeout: in any non-IDLE state, an idle counter runs and clears on each `fall`. On reaching `TIMEOUT` the FSM returns to IDLE, sets `ferr`, and drops the byte.
- FIFO:
  - Pointers are `$clog2(DEPTH)+1` bits; count = wr−rd.
  - A push while full drops the byte and sets `ovr`.
- Pop: occurs on a rising edge of `pr` (pr high, previous-cycle `pr` low) with `address`==`DATA_PORT` and FIFO non-empty.
- Simultaneous push and pop, FIFO full: the pop frees a slot, the push is accepted, count is unchanged, and `ovr` is not set.
- Read data:
  - `DATA_PORT`: FIFO head, or 8'h00 if empty.
  - `STAT_PORT`: {4'b0, ferr, perr, ovr, ~empty}.
  - Any other address: 8'hFF with `hit`=0.
- Writes:
  - `pw` with `address`==`STAT_PORT` clears `ovr`/`perr`/`ferr` on that edge. A same-cycle set wins over the clear.
  - `pw` to `DATA_PORT` is ignored.

## Timing
- Reset values:
  - FIFO empty; FSM in IDLE; flags 0; idle counter 0.
  - Filtered clock level 1; previous `pr` 0.
  - `port_in` is 8'h00 while `address`==`DATA_PORT` (FIFO empty).
  - `irq` is 0.
  - Reset is asynchronous and may occur mid-frame: the partial byte is discarded.
- Latency:
  - A `ps2_clk` edge is recognised 2+`FILTER` cycles after the pin transition.
  - A byte is readable on the cycle after the STOP `fall`.
- A `pr` held high for several cycles pops exactly once.
- After a pop, `port_in` shows the new head on the next cycle.

## Configuration
- `KBD_IRQ_EN` defined: `irq` output exists, registered, high while the FIFO is non-empty; it drops the cycle after the last pop.
- `KBD_IRQ_EN` undefined: no `irq` port; the rest of the behaviour is identical.

## Structure
- `kbd_pkg` holds:
  - Default port numbers.
  - Status bit indices: OBF=0, OVR=1, PERR=2, FERR=3.
  - Receiver state encoding: IDLE, DATA, PARITY, STOP.
- Sub-module `ps2_rx`: synchroniser, filter, FSM, and timeout; outputs `valid`/`byte`/`perr`/`ferr` pulses.
- `kbd_port` holds the FIFO, status register, and port decode.

## Test plan
- Send frame 0x1C (valid odd parity) → status reads 8'h01; data port reads 0x1C; status then reads 8'h00.
- Send 0x1C with a flipped parity bit → status 8'h04; FIFO empty; write 8'h00 to 64h → status 8'h00.
- Send 17 frames 0x01..0x11 with `DEPTH`=16 → status bit1 set; reads return 0x01..0x10 in order, then empty.
- Stop after 4 data bits for >`TIMEOUT` cycles, then send 0x5A → status 8'h09; data port reads 0x5A.
- Hold `pr` at 60h for 5 cycles with 2 bytes queued → exactly one pop; next read returns the second byte.
- Assert `reset_n`=0 mid-frame → all outputs at reset values; a following clean 0x2A frame is received correctly.
